// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the banked main-memory port between the
// I-cache and D-cache miss controllers, one whole line per grant.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int BEATS   = 4,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          i_gnt,
  output logic          d_gnt,
  output logic [DW-1:0] rdata,
  output logic          i_rvalid,
  output logic          d_rvalid,
  output logic          d_wack,
  output logic          i_done,
  output logic          d_done,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic [3:0]    mem_busy,
  input  logic          mem_stall
);

  localparam int KW = $clog2(BEATS);
  localparam int CW = KW + 1;
  localparam int LW = AW - KW - 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [KW-1:0]     beat;
  logic [CW-1:0]     ret_cnt;
  logic [LATENCY-1:0] inflight;
  logic [LW-1:0]     line;
  logic              owner_d;
  logic              op_wr;
  logic              rr_d;

  logic              bank_free;
  logic              issue;
  logic              last_beat;
  logic              rvalid;
  logic              last_ret;
  logic              pick_d;
  logic              unused_ok;

  // Beat issue gating, read-return steering and port-facing outputs
  always_comb begin
    bank_free = !mem_stall && !mem_busy[beat];
    issue     = (state == ISSUE) && bank_free;
    last_beat = (beat == KW'(BEATS - 1));
    rvalid    = inflight[LATENCY-1];
    last_ret  = rvalid && (ret_cnt == CW'(BEATS - 1));
    pick_d    = d_req && (rr_d || !i_req);
    mem_rd    = issue && !op_wr;
    mem_wr    = issue && op_wr;
    d_wack    = mem_wr;
    mem_addr  = '0;
    if (state == ISSUE)
      mem_addr = {line, beat, 1'b0};
    mem_wdata = mem_wr ? d_wdata : '0;
    rdata     = rvalid ? mem_rdata : '0;
    i_rvalid  = rvalid && !owner_d;
    d_rvalid  = rvalid && owner_d;
    unused_ok = ^{i_addr[KW:0], d_addr[KW:0]};
  end

  // In-flight read tracker: one bit per cycle of memory latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      inflight <= '0;
    else
      inflight <= (inflight << 1) | LATENCY'(mem_rd);
  end

  // Transaction FSM with registered grant and done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      ret_cnt <= '0;
      line    <= '0;
      owner_d <= 1'b0;
      op_wr   <= 1'b0;
      rr_d    <= 1'b1;
      i_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      if (rvalid)
        ret_cnt <= ret_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          beat    <= '0;
          ret_cnt <= '0;
          if (pick_d) begin
            owner_d <= 1'b1;
            op_wr   <= d_wr;
            line    <= d_addr[AW-1:KW+1];
            d_gnt   <= 1'b1;
            state   <= ISSUE;
          end else if (i_req) begin
            owner_d <= 1'b0;
            op_wr   <= 1'b0;
            line    <= i_addr[AW-1:KW+1];
            i_gnt   <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              if (op_wr) begin
                state  <= DONE;
                i_done <= !owner_d;
                d_done <= owner_d;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (last_ret) begin
            state  <= DONE;
            i_done <= !owner_d;
            d_done <= owner_d;
          end
        end
        DONE: begin
          i_done <= 1'b0;
          d_done <= 1'b0;
          i_gnt  <= 1'b0;
          d_gnt  <= 1'b0;
          rr_d   <= !owner_d;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven line transactions with a memory model
// and issue/return scoreboards, plus arbitration and reset sequences.
module tb_mem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          d_req;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt;
  logic          d_gnt;
  logic [DW-1:0] rdata;
  logic          i_rvalid;
  logic          d_rvalid;
  logic          d_wack;
  logic          i_done;
  logic          d_done;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [3:0]    mem_busy;
  logic          mem_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .BEATS(4), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr),
    .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .rdata(rdata),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid),
    .d_wack(d_wack), .i_done(i_done), .d_done(d_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .mem_stall(mem_stall)
  );

  typedef struct {
    logic        side;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } iss_t;

  typedef struct {
    logic        side;
    logic [15:0] data;
  } ret_t;

  typedef struct {
    logic        side;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wbase;
    int          busy_bank;
    int          busy_at;
    int          busy_len;
    int          stall_at;
    int          drop_at;
    int          exp_last;
    int          exp_done;
  } vec_t;

  iss_t iss_q[$];
  ret_t ret_q[$];
  int   done_seq[$];
  vec_t tbl[6];

  int ntests = 0;
  int nfail  = 0;
  int mon_cyc, first_gnt_i, first_gnt_d, last_gnt_i, last_gnt_d;
  int both_gnt, issues, last_issue, rvals, last_rval, wacks;
  int done_i, done_d, done_cyc;
  logic [15:0] wbase;
  logic        pv[LAT];
  logic [15:0] pa[LAT];

  function automatic logic [15:0] mem_fn(logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    mon_cyc = 0;
    first_gnt_i = -1; first_gnt_d = -1;
    last_gnt_i = -1;  last_gnt_d = -1;
    both_gnt = 0; issues = 0; last_issue = -1;
    rvals = 0; last_rval = -1; wacks = 0;
    done_i = 0; done_d = 0; done_cyc = -1;
    done_seq.delete();
  endtask

  task automatic observe();
    iss_t e;
    ret_t r;
    if (i_gnt) begin
      if (first_gnt_i < 0) first_gnt_i = mon_cyc;
      last_gnt_i = mon_cyc;
    end
    if (d_gnt) begin
      if (first_gnt_d < 0) first_gnt_d = mon_cyc;
      last_gnt_d = mon_cyc;
    end
    if (i_gnt && d_gnt) both_gnt++;
    if (mem_rd || mem_wr) begin
      chk("strobe_blocked",
          {31'b0, mem_stall | mem_busy[mem_addr[2:1]]}, 0);
      chk("strobe_both", {31'b0, mem_rd & mem_wr}, 0);
      chk("wack_match", {31'b0, d_wack}, {31'b0, mem_wr});
      if (iss_q.size() == 0) begin
        chk("issue_extra", 1, 0);
      end else begin
        e = iss_q.pop_front();
        chk("issue_addr", {16'b0, mem_addr}, {16'b0, e.addr});
        chk("issue_wr", {31'b0, mem_wr}, {31'b0, e.wr});
        chk("issue_gnt", {31'b0, e.side ? d_gnt : i_gnt}, 1);
        if (e.wr)
          chk("issue_wdata", {16'b0, mem_wdata}, {16'b0, e.wdata});
        else
          ret_q.push_back('{e.side, mem_fn(e.addr)});
      end
      issues++;
      last_issue = mon_cyc;
      if (d_wack) wacks++;
    end else if (d_wack) begin
      chk("wack_stray", 1, 0);
    end
    if (i_rvalid || d_rvalid) begin
      chk("rvalid_both", {31'b0, i_rvalid & d_rvalid}, 0);
      if (ret_q.size() == 0) begin
        chk("ret_extra", 1, 0);
      end else begin
        r = ret_q.pop_front();
        chk("ret_side", {31'b0, d_rvalid}, {31'b0, r.side});
        chk("ret_data", {16'b0, rdata}, {16'b0, r.data});
      end
      rvals++;
      last_rval = mon_cyc;
    end
    if (i_done) begin
      done_i++; done_cyc = mon_cyc; done_seq.push_back(0);
    end
    if (d_done) begin
      done_d++; done_cyc = mon_cyc; done_seq.push_back(1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pa[i] = pa[i-1];
    end
    pv[0] = mem_rd;
    pa[0] = mem_addr;
    @(posedge clk);
    #1;
    mem_rdata = pv[LAT-1] ? mem_fn(pa[LAT-1]) : 16'h0BAD;
    mon_cyc++;
    d_wdata = wbase + 16'(wacks);
  endtask

  task automatic push_txn(logic side, logic wr,
                          logic [15:0] addr, logic [15:0] wb);
    for (int k = 0; k < 4; k++)
      iss_q.push_back('{side, wr, (addr & 16'hFFF8) + 16'(2 * k),
                        wb + 16'(k)});
  endtask

  task automatic run_txn(vec_t v);
    logic rq;
    int own_first, oth_first, own_last, own_done, oth_done;
    clear_mon();
    wbase = v.wbase;
    d_wdata = v.wbase;
    push_txn(v.side, v.wr, v.addr, v.wbase);
    for (int c = 0; c < 40; c++) begin
      rq = (c < v.drop_at) && (done_i + done_d == 0);
      if (v.side) begin
        d_req = rq; d_wr = v.wr; d_addr = v.addr;
      end else begin
        i_req = rq; i_addr = v.addr;
      end
      mem_busy = (c >= v.busy_at && c < v.busy_at + v.busy_len)
               ? 4'(1 << v.busy_bank) : 4'b0;
      mem_stall = (c == v.stall_at);
      tick();
      if (done_i + done_d > 0 && mon_cyc >= done_cyc + 3) break;
    end
    i_req = 0; d_req = 0; mem_busy = 0; mem_stall = 0;
    own_first = v.side ? first_gnt_d : first_gnt_i;
    oth_first = v.side ? first_gnt_i : first_gnt_d;
    own_last  = v.side ? last_gnt_d : last_gnt_i;
    own_done  = v.side ? done_d : done_i;
    oth_done  = v.side ? done_i : done_d;
    chk("gnt_first", own_first, 1);
    chk("gnt_other", oth_first, -1);
    chk("gnt_last", own_last, done_cyc);
    chk("issues", issues, 4);
    chk("last_issue", last_issue, v.exp_last);
    chk("rvalids", rvals, v.wr ? 0 : 4);
    if (!v.wr) chk("last_rvalid", last_rval, v.exp_last + LAT);
    chk("wacks", wacks, v.wr ? 4 : 0);
    chk("done_own", own_done, 1);
    chk("done_other", oth_done, 0);
    chk("done_cyc", done_cyc, v.exp_done);
    chk("iss_q_left", iss_q.size(), 0);
    chk("ret_q_left", ret_q.size(), 0);
    iss_q.delete();
    ret_q.delete();
  endtask

  initial begin
    vec_t fresh;
    tbl[0] = '{1'b0, 1'b0, 16'h0120, 16'h0000, 0, 0, 0, -1, 99, 4, 7};
    tbl[1] = '{1'b1, 1'b1, 16'h00F8, 16'h00A0, 0, 0, 0, -1, 99, 4, 5};
    tbl[2] = '{1'b0, 1'b0, 16'h0120, 16'h0000, 2, 3, 3, -1, 99, 7, 10};
    tbl[3] = '{1'b1, 1'b0, 16'h0207, 16'h0000, 0, 0, 0, 2, 2, 5, 8};
    tbl[4] = '{1'b1, 1'b1, 16'h1234, 16'h7700, 0, 0, 3, -1, 99, 6, 7};
    tbl[5] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 3, 4, 1, -1, 99, 5, 8};
    fresh  = '{1'b0, 1'b0, 16'h0340, 16'h0000, 0, 0, 0, -1, 99, 4, 7};

    rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0;
    d_wdata = 0; mem_rdata = 0; mem_busy = 0; mem_stall = 0; wbase = 0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 0; pa[i] = 0;
    end
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {31'b0, |{i_gnt, d_gnt, rdata, i_rvalid, d_rvalid,
        d_wack, i_done, d_done, mem_rd, mem_wr, mem_addr, mem_wdata}}, 0);
    rst = 0;
    repeat (2) tick();
    chk("idle_quiet", first_gnt_i + first_gnt_d + issues, -2);

    // Both sides request together after reset: D first, then alternate
    clear_mon();
    for (int r = 0; r < 3; r++) begin
      push_txn(1'b1, 1'b0, 16'h0400, 16'h0);
      push_txn(1'b0, 1'b0, 16'h0500, 16'h0);
    end
    i_addr = 16'h0500; d_addr = 16'h0400; d_wr = 0;
    i_req = 1; d_req = 1;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (done_seq.size() >= 6) break;
    end
    i_req = 0; d_req = 0;
    repeat (3) tick();
    chk("arb_first_d", first_gnt_d, 1);
    chk("arb_dones", done_seq.size(), 6);
    for (int k = 0; k < done_seq.size() && k < 6; k++)
      chk("arb_order", done_seq[k], (k % 2 == 0) ? 1 : 0);
    chk("arb_both_gnt", both_gnt, 0);
    chk("arb_iss_left", iss_q.size(), 0);
    chk("arb_ret_left", ret_q.size(), 0);
    iss_q.delete();
    ret_q.delete();

    for (int t = 0; t < 6; t++)
      run_txn(tbl[t]);

    // Reset while draining read returns
    clear_mon();
    push_txn(1'b0, 1'b0, 16'h0300, 16'h0);
    i_addr = 16'h0300; i_req = 1;
    repeat (5) tick();
    chk("drain_pre_rvals", rvals, 2);
    rst = 1; i_req = 0;
    #1;
    chk("drain_rst_outs", {31'b0, |{i_gnt, d_gnt, rdata, i_rvalid,
        d_rvalid, d_wack, i_done, d_done, mem_rd, mem_wr, mem_addr,
        mem_wdata}}, 0);
    chk("drain_iss_left", iss_q.size(), 0);
    ret_q.delete();
    tick();
    rst = 0;
    repeat (6) tick();
    chk("drain_post_rvals", rvals, 2);
    chk("drain_post_done", done_i + done_d, 0);
    chk("drain_post_gnt", {31'b0, i_gnt | d_gnt}, 0);
    run_txn(fresh);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single four-bank main-memory port between the instruction-cache and data-cache miss controllers.
- Grants one requester per whole-line transaction of BEATS words.
- Issues each beat only when its target bank is not busy, and steers read data back to the owner.
- Sits between the two cache controllers and the banked memory.

Parameters:
AW, 16, address width (byte address, 16-bit words)
DW, 16, data width
BEATS, 4, words per line transaction (power of two, equals the bank count)
LATENCY, 2, cycles from a read beat issue to mem_rdata valid

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
i_req  input  1  I-side line read request; held until i_done
i_addr  input  AW  I-side line base address
d_req  input  1  D-side line request; held until d_done
d_wr  input  1  D-side transaction is a writeback (1) or fill read (0)
d_addr  input  AW  D-side line base address
d_wdata  input  DW  D-side write beat data; advances after each d_wack
i_gnt  output  1  I-side owns the port
d_gnt  output  1  D-side owns the port
rdata  output  DW  returned read word (mem_rdata forwarded)
i_rvalid  output  1  rdata valid for I-side
d_rvalid  output  1  rdata valid for D-side
d_wack  output  1  current d_wdata beat consumed this cycle
i_done  output  1  one-cycle pulse, I-side transaction complete
d_done  output  1  one-cycle pulse, D-side transaction complete
mem_rd  output  1  read beat issue strobe
mem_wr  output  1  write beat issue strobe
mem_addr  output  AW  beat address
mem_wdata  output  DW  write beat data
mem_rdata  input  DW  memory read data
mem_busy  input  4  per-bank busy
mem_stall  input  1  memory cannot accept any access this cycle

Behaviour:
- Reset: state IDLE, beat counter 0, in-flight tracker cleared, RR pointer favours D-side. All outputs 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - Sample requests.
  - One request pending: grant it.
  - Both pending: grant the side the RR pointer favours.
  - Latch owner, line base, and op (I-side is always a read).
  - Next state ISSUE; gnt is registered and rises the next cycle.
- gnt stays high from ISSUE entry through the DONE cycle inclusive. At most one gnt is high at any time.
- Beat k address: {base[AW-1:3], k[1:0], 1'b0}. Target bank is addr[2:1]. Base low 3 bits are ignored.
- ISSUE:
  - Beat k issues in the current cycle when !mem_stall && !mem_busy[bank].
  - On issue, mem_rd or mem_wr is high for exactly that cycle, and k increments.
  - When blocked, the strobes are low, k holds, and the beat retries next cycle.
  - Write beats: mem_wdata = d_wdata, and d_wack pulses in the issue cycle.
  - After the last beat issues: writes go to DONE; reads go to DRAIN.
- Read return:
  - A LATENCY-deep shift register marks issued read beats.
  - LATENCY cycles after each issue, rdata = mem_rdata and the owner's rvalid pulses.
  - Returns are in issue order.
- DRAIN: wait until all BEATS returns have been delivered, then go to DONE. This may overlap the ISSUE tail; no beat is ever dropped.
- DONE:
  - Owner's done pulses one cycle.
  - RR pointer flips to favour the other side.
  - Next state IDLE; gnt falls on entry to IDLE.
- A requester dropping req mid-transaction is ignored; the transaction completes. A req still high in IDLE after done is treated as a new request.
- Minimum read transaction with no busy banks: gnt cycle 1, beats issue cycles 1–4, last rvalid cycle 4+LATENCY, done the following cycle.
- Reset mid-operation: immediate return to reset state. In-flight returns are discarded and produce no rvalid.

Test Plan:
- I-read alone, addr 0x0120, no busy: mem_rd strobes at 0x0120/0x0122/0x0124/0x0126 on 4 consecutive cycles; 4 i_rvalid pulses LATENCY later with data in order; i_done once; d_gnt stays 0.
- D-writeback alone, addr 0x00F8, d_wdata 0xA0..0xA3: mem_wr carries those words at 0x00F8..0x00FE; 4 d_wack pulses; d_done without a DRAIN wait.
- Both request in the same cycle after reset: D granted first. I must be granted next even if D re-requests immediately (alternation persists over 3 rounds).
- mem_busy[2] high for 3 cycles during beat 2 of a read: beat 2 is delayed exactly 3 cycles, no strobe while blocked, beats 0–3 still issued once each in order, done delayed 3 cycles.
- mem_stall pulse plus req drop mid-transaction: transaction completes with all 4 beats and a done pulse.
- rst asserted during DRAIN: all outputs 0 the same cycle; no later rvalid or done; a fresh I-read then completes normally.
